// File: rtl/accu_sum_fifo.sv
// accu_sum_fifo: buffers 10-bit accumulator sums and hands them to a consumer
// over a valid/ready handshake. Holds up to DEPTH entries. A sum that arrives
// while the FIFO is full and nothing is leaving is dropped, and the sticky
// overflow flag records the loss.
// Optional build macro: ACCU_AVG_EN. When it is defined, data_out presents
// the head sum divided by 8 (truncated mean). Storage keeps the full sum.
module accu_sum_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] head_next;
    logic              push, pop, full_w, empty_w, none_left;

    assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_w = (count_q == '0);

    // Handshake decode, pointer/count/flag updates and next registered head.
    always_comb begin
        pop        = ~empty_w & ready_in;
        push       = valid_in & (~full_w | pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        head_next  = '0;
        data_out_d = '0;

        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
        else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);

        // A drop on the same edge as a clear must leave the flag set.
        if (clr_ovf)                   overflow_d = 1'b0;
        if (valid_in && !push)         overflow_d = 1'b1;

        // If no stored entry survives this edge, the new head (if any) is the
        // word being written now, so take it straight from data_in; the
        // memory location will not hold it until after the edge.
        none_left = empty_w || (pop && count_q == (ADDR_W+1)'(1));
        if (none_left) head_next = data_in;
        else           head_next = mem_q[rd_ptr_d];

        if (count_d != '0) begin
`ifdef ACCU_AVG_EN
            data_out_d = {3'b000, head_next[DATA_W-1:3]};
`else
            data_out_d = head_next;
`endif
        end
    end

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    // Control state and registered output word, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            data_out_q <= data_out_d;
        end
    end

    assign valid_out = ~empty_w;
    assign data_out  = data_out_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_accu_sum_fifo.sv
// Directed bench for accu_sum_fifo with a queue scoreboard and a small
// occupancy/overflow model. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_accu_sum_fifo;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;

    accu_sum_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] sb[$];
    int   mcount = 0;
    logic movf   = 1'b0;

    function automatic logic [DATA_W-1:0] exp_val(input logic [DATA_W-1:0] x);
`ifdef ACCU_AVG_EN
        return x >> 3;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check outputs at negedge against the model, update the
    // model/scoreboard with this cycle's handshake, then advance to posedge+1.
    task automatic cycle();
        logic e_pop, e_push;
        logic [DATA_W-1:0] e_data;
        @(negedge clk);
        e_data = (mcount > 0) ? sb[0] : '0;
        chk("valid_out", 32'(valid_out), 32'(mcount > 0));
        chk("count",     32'(count),     32'(mcount));
        chk("full",      32'(full),      32'(mcount == DEPTH));
        chk("empty",     32'(empty),     32'(mcount == 0));
        chk("overflow",  32'(overflow),  32'(movf));
        chk("data_out",  32'(data_out),  32'(e_data));
        e_pop  = (mcount > 0) && ready_in;
        e_push = valid_in && ((mcount < DEPTH) || e_pop);
        if (e_pop) begin
            $display("pop  data_out=%0h expected=%0h count=%0d", data_out, e_data, mcount);
            void'(sb.pop_front());
        end
        if (e_push) begin
            sb.push_back(exp_val(data_in));
            $display("push data_in=%0h count=%0d", data_in, mcount);
        end else if (valid_in) begin
            $display("drop data_in=%0h (full)", data_in);
        end
        if (clr_ovf) movf = 1'b0;
        if (valid_in && !e_push) movf = 1'b1;
        mcount = mcount + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            data_in  = DATA_W'(base + i);
            cycle();
        end
        valid_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},    32'(valid_out), 32'(0));
        chk({tag, "_data"},     32'(data_out),  32'(0));
        chk({tag, "_count"},    32'(count),     32'(0));
        chk({tag, "_full"},     32'(full),      32'(0));
        chk({tag, "_empty"},    32'(empty),     32'(1));
        chk({tag, "_overflow"}, 32'(overflow),  32'(0));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single push, visible next cycle
        valid_in = 1'b1; data_in = 10'h0F0;
        cycle();
        valid_in = 1'b0;
        @(negedge clk);
`ifdef ACCU_AVG_EN
        chk("t1_data", 32'(data_out), 32'h01E);
`else
        chk("t1_data", 32'(data_out), 32'h0F0);
`endif
        chk("t1_count", 32'(count), 32'(1));
        @(posedge clk); #1;
        ready_in = 1'b1;
        repeat (2) cycle();

        // 2: overfill with consumer stalled, then drain
        ready_in = 1'b0;
        fill(5, 1);
        cycle();
        ready_in = 1'b1;
        repeat (5) cycle();
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        cycle();

        // 3: full, simultaneous pop and push
        ready_in = 1'b0;
        fill(4, 10'h040);
        valid_in = 1'b1; data_in = 10'h3FF; ready_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        repeat (5) cycle();

        // 4: streaming push every cycle with consumer ready, pointers wrap
        ready_in = 1'b1;
        fill(9, 10'h100);
        repeat (2) cycle();

        // 5: clear coinciding with a drop, then clear alone
        ready_in = 1'b0;
        fill(4, 10'h200);
        valid_in = 1'b1; data_in = 10'h2AA; cycle();
        clr_ovf = 1'b1; data_in = 10'h2BB; cycle();
        valid_in = 1'b0; cycle();
        clr_ovf = 1'b0; cycle();
        ready_in = 1'b1;
        repeat (5) cycle();

        // 6: asynchronous reset mid-drain with three entries stored
        ready_in = 1'b0;
        fill(4, 10'h300);
        ready_in = 1'b1;
        cycle();
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        sb.delete(); mcount = 0; movf = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) cycle();
        valid_in = 1'b1; data_in = 10'h155; cycle();
        valid_in = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
